result_reader: RTL

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/result_reader.sv
// ---------------------------------------------------------------------------
// result_reader
//
// Reads one frame of convolution results (COUNT words starting at address
// BASE) from a memory with one-cycle read latency and streams them out
// through a valid/ready interface. A 2-entry FIFO decouples the memory
// reads from the sink, and reads are throttled so the FIFO can never
// overflow.
//
// Optional feature: define RD_ROW_MARK_EN to add output rowEnd. It flags
// the last word of every ROW_LEN-word output row.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   start      request to read one frame (honoured in IDLE or DONE only)
//   memRead    memory read strobe
//   memAddress read address (0 while memRead=0)
//   memData    read data, valid the cycle after memRead
//   outData    streamed result word (0 while outValid=0)
//   outValid   outData holds a word
//   outReady   sink accepts the word
//   busy       frame in progress (FETCH or DRAIN)
//   done       frame complete (DONE)
//   rowEnd     (RD_ROW_MARK_EN only) current word ends an output row
// ---------------------------------------------------------------------------
module result_reader #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int BASE    = 332,
  parameter int COUNT   = 169,
  parameter int ROW_LEN = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              memRead,
  output logic [ADDR_W-1:0] memAddress,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
`ifdef RD_ROW_MARK_EN
  output logic              done,
  output logic              rowEnd
`else
  output logic              done
`endif
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [CNT_W-1:0]  issue_cnt_reg;
  logic [CNT_W-1:0]  xfer_cnt_reg;
  logic              inflight_reg;

  logic [DATA_W-1:0] fifo_data_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        fifo_cnt_reg;

  logic              push;
  logic              pop;
  logic              launch;
  logic [1:0]        pending;
  logic              last_issue;
  logic              last_xfer;

  // The word returned by the memory is always pushed the cycle after the
  // read, so the in-flight flag doubles as the FIFO push strobe.
  assign push = inflight_reg;
  assign pop  = outValid && outReady;

  // Occupancy the FIFO will have once this cycle's pop (if any) leaves,
  // plus the read already in flight. Counting the pop lets a read issue in
  // the same cycle a word drains, which sustains one word per cycle while
  // still guaranteeing at most 2 words stored or owed at any time.
  assign pending = fifo_cnt_reg - {1'b0, pop} + {1'b0, inflight_reg};

  assign launch     = (state_reg == FETCH) && (pending < 2'd2);
  assign last_issue = (issue_cnt_reg == CNT_W'(COUNT - 1));
  assign last_xfer  = (xfer_cnt_reg == CNT_W'(COUNT - 1));

  assign memRead    = launch;
  assign memAddress = launch ? (ADDR_W'(BASE) + ADDR_W'(issue_cnt_reg)) : '0;

  assign outValid = (fifo_cnt_reg != 2'd0);
  assign outData  = outValid ? fifo_data_reg[rd_ptr_reg] : '0;
  assign busy     = busy_reg;
  assign done     = done_reg;

  // FIFO storage: plain registers without reset; outData is gated by
  // outValid so stale contents never reach the port.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_data_reg[gi] <= memData;
        end
      end
    end
  endgenerate

  // Control: FSM, counters and FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      issue_cnt_reg <= '0;
      xfer_cnt_reg  <= '0;
      inflight_reg  <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      fifo_cnt_reg  <= 2'd0;
    end else begin
      inflight_reg <= launch;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
      if (launch) issue_cnt_reg <= issue_cnt_reg + 1'b1;
      if (pop)    xfer_cnt_reg  <= xfer_cnt_reg + 1'b1;

      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= FETCH;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            issue_cnt_reg <= '0;
            xfer_cnt_reg  <= '0;
          end
        end
        FETCH: begin
          if (launch && last_issue) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (pop && last_xfer) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef RD_ROW_MARK_EN
  localparam int COL_W = $clog2(ROW_LEN + 1);

  logic [COL_W-1:0] col_reg;
  logic             inflight_mark_reg;
  logic             fifo_mark_reg [2];
  logic             col_last;

  // The row mark is decided when the read issues and travels with the word.
  assign col_last = (col_reg == COL_W'(ROW_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg           <= '0;
      inflight_mark_reg <= 1'b0;
    end else begin
      inflight_mark_reg <= launch && col_last;
      if ((state_reg == IDLE || state_reg == DONE) && start) begin
        col_reg <= '0;
      end else if (launch) begin
        col_reg <= col_last ? '0 : col_reg + 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_mark
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_mark_reg[gi] <= inflight_mark_reg;
        end
      end
    end
  endgenerate

  assign rowEnd = outValid && fifo_mark_reg[rd_ptr_reg];
`endif

endmodule
